// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe: N-input W-bit select mux into a two-entry skid buffer; `MUX_NTO1_SEL_CHECK_EN enables the sticky SelErr flag
module mux_nto1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [NUM_IN*WIDTH-1:0] DataIn,
  input  logic [SEL_W-1:0]        Sel,
  input  logic                    InValid,
  output logic                    InReady,
  output logic [WIDTH-1:0]        DataOut,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic                    SelErr
);
  if (NUM_IN < 2 || NUM_IN > (1 << SEL_W)) begin : g_bad_params
    $error("mux_nto1_pipe: NUM_IN=%0d outside 2..2**SEL_W", NUM_IN);
  end
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b11} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] head_q, skid_q, word;
  logic             accept, take, load_head, load_skid, pop_skid;
  assign InReady  = (state_q != TWO);
  assign OutValid = (state_q != EMPTY);
  assign DataOut  = head_q;
  assign accept   = InValid & InReady;
  assign take     = OutValid & OutReady;
  // select the offered word; an out-of-range Sel matches no lane and yields zero
  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (Sel == SEL_W'(i)) word = DataIn[i*WIDTH +: WIDTH];
  end
  // next state and storage-load decisions from current state and handshakes
  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    case (state_q)
      EMPTY: begin
        load_head = accept;
        state_d   = accept ? ONE : EMPTY;
      end
      ONE: begin
        load_head = accept & take;
        load_skid = accept & ~take;
        state_d   = (accept & ~take) ? TWO : (take & ~accept) ? EMPTY : ONE;
      end
      TWO: begin
        pop_skid = take;
        state_d  = take ? ONE : TWO;
      end
      default: state_d = EMPTY;
    endcase
  end
  // state register; reset discards both entries at once
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end
  // head and skid data registers; head keeps its last word after draining
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_head)     head_q <= word;
      else if (pop_skid) head_q <= skid_q;
      if (load_skid)     skid_q <= word;
    end
  end
`ifdef MUX_NTO1_SEL_CHECK_EN
  logic sel_bad, sel_err_q;
  assign sel_bad = (int'(Sel) >= NUM_IN);
  assign SelErr  = sel_err_q;
  // sticky flag: any accepted out-of-range select latches until reset
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)               sel_err_q <= 1'b0;
    else if (accept && sel_bad) sel_err_q <= 1'b1;
  end
`else
  assign SelErr = 1'b0;
`endif
endmodule
